// File: rtl/board_io_pkg.sv
// Shared types and register map for the board I/O controller.
package board_io_pkg;

  // Per-LED drive mode, two bits per LED in the LED_MODE register.
  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_PWM   = 2'd3
  } led_mode_t;

  // Word register indices on the 3-bit address bus.
  localparam logic [2:0] REG_BTN_STATE  = 3'd0;
  localparam logic [2:0] REG_BTN_EVENT  = 3'd1;
  localparam logic [2:0] REG_EVENT_MASK = 3'd2;
  localparam logic [2:0] REG_LED_MODE   = 3'd3;
  localparam logic [2:0] REG_PWM_DUTY   = 3'd4;
  localparam logic [2:0] REG_LED_STATE  = 3'd5;

endpackage

// File: rtl/board_io_debounce.sv
// One button: 2-flop synchronizer, polarity fix-up and ms-tick stability counter.
module board_io_debounce #(
  parameter logic ACTIVE_LOW  = 1'b0,
  parameter int   DEBOUNCE_MS = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  input  logic ms_tick_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_MS - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] count_q, count_d;
  logic          pressed;

  // Synchronized level normalised so that 1 always means pressed.
  assign pressed = sync_q[1] ^ ACTIVE_LOW;

  // Count ticks while the input disagrees with the debounced level; any
  // agreeing cycle restarts the count so short glitches never accumulate.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    level_d = level_q;
    count_d = count_q;
    rise_o  = 1'b0;
    if (pressed == level_q) begin
      count_d = '0;
    end else if (ms_tick_i) begin
      if (count_q == LAST) begin
        level_d = pressed;
        count_d = '0;
        rise_o  = pressed;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Synchronizer and debounce state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      count_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      count_q <= count_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O controller: debounced buttons with events/irq, LED modes, word register bus.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int               FREQUENCY      = 25_000_000,
  parameter int               NUM_BTN        = 7,
  parameter int               NUM_LED        = 8,
  parameter logic [NUM_BTN-1:0] BTN_ACTIVE_LOW = 7'b0000001,
  parameter int               DEBOUNCE_MS    = 10,
  parameter int               BLINK_HZ       = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_LED-1:0] led,
  input  logic               sel,
  input  logic               we,
  input  logic [2:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic               irq
);

  localparam int MS_DIV    = (FREQUENCY / 1000 > 1) ? FREQUENCY / 1000 : 1;
  localparam int BLINK_DIV = (FREQUENCY / (2 * BLINK_HZ) > 1) ? FREQUENCY / (2 * BLINK_HZ) : 1;
  localparam logic [31:0] MS_LAST    = 32'(MS_DIV - 1);
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_DIV - 1);

  logic [31:0]          presc_q, blink_cnt_q;
  logic                 blink_q;
  logic [7:0]           pwm_cnt_q;
  logic                 ms_tick;
  logic [NUM_BTN-1:0]   level, rise, clr;
  logic [NUM_BTN-1:0]   event_q, event_d, mask_q;
  logic [2*NUM_LED-1:0] mode_q;
  logic [7:0]           duty_q;
  logic [NUM_LED-1:0]   led_q, led_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 ready_q, irq_q;
  logic                 wr_en;
  logic                 unused_wdata;

  assign wr_en        = sel & we;
  assign ms_tick      = (presc_q == MS_LAST);
  assign unused_wdata = ^wdata;

  // Free-running timebases: ms prescaler, blink phase and PWM counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      pwm_cnt_q   <= '0;
    end else begin
      presc_q <= ms_tick ? '0 : presc_q + 32'd1;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 32'd1;
      end
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    board_io_debounce #(
      .ACTIVE_LOW  (BTN_ACTIVE_LOW[i]),
      .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_debounce (
      .clk       (clk),
      .reset     (reset),
      .btn_i     (btn[i]),
      .ms_tick_i (ms_tick),
      .level_o   (level[i]),
      .rise_o    (rise[i])
    );
  end

  // Event bits: write-one-to-clear, with a hardware rise in the same cycle taking priority.
  always_comb begin
    clr = '0;
    if (wr_en && addr == REG_BTN_EVENT) clr = wdata[NUM_BTN-1:0];
    event_d = (event_q & ~clr) | rise;
  end

  // LED drive per mode; registered below so writes and phase changes show one cycle later.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      case (led_mode_t'(mode_q[2*i +: 2]))
        LED_ON:    led_d[i] = 1'b1;
        LED_BLINK: led_d[i] = blink_q;
        LED_PWM:   led_d[i] = (pwm_cnt_q < duty_q);
        default:   led_d[i] = 1'b0;
      endcase
    end
  end

  // Read mux; unimplemented bits and addresses return 0, idle cycles return 0.
  always_comb begin
    rdata_d = '0;
    if (sel) begin
      case (addr)
        REG_BTN_STATE:  rdata_d[NUM_BTN-1:0]   = level;
        REG_BTN_EVENT:  rdata_d[NUM_BTN-1:0]   = event_q;
        REG_EVENT_MASK: rdata_d[NUM_BTN-1:0]   = mask_q;
        REG_LED_MODE:   rdata_d[2*NUM_LED-1:0] = mode_q;
        REG_PWM_DUTY:   rdata_d[7:0]           = duty_q;
        REG_LED_STATE:  rdata_d[NUM_LED-1:0]   = led_q;
        default:        rdata_d                = '0;
      endcase
    end
  end

  // Register file, bus response and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      event_q <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      duty_q  <= '0;
      led_q   <= '0;
      irq_q   <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      event_q <= event_d;
      if (wr_en && addr == REG_EVENT_MASK) mask_q <= wdata[NUM_BTN-1:0];
      if (wr_en && addr == REG_LED_MODE)   mode_q <= wdata[2*NUM_LED-1:0];
      if (wr_en && addr == REG_PWM_DUTY)   duty_q <= wdata[7:0];
      led_q   <= led_d;
      irq_q   <= |(event_q & mask_q);
      ready_q <= sel;
      rdata_q <= rdata_d;
    end
  end

  assign led   = led_q;
  assign irq   = irq_q;
  assign ready = ready_q;
  assign rdata = rdata_q;

endmodule
